// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data RAM.
// CPU and HOST requesters share it one access at a time via IDLE/ACC/RD.
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRI  = 0,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        arb_state,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t           state;
    state_t           state_nx;
    logic             win_q;
    logic             we_q;
    logic             last_win;
    logic             any_req;
    logic             tie_host;
    logic             pick_host;
    logic [CNT_W-1:0] starve_cnt;

    assign any_req = cpu_req | host_req;

    // Winner encoding: 0 = CPU, 1 = HOST.
    always_comb begin
        tie_host = ~last_win;
        if (FIXED_PRI != 0) begin
            tie_host = (starve_cnt == CNT_MAX);
        end
    end

    always_comb begin
        pick_host = 1'b0;
        if (cpu_req && host_req) begin
            pick_host = tie_host;
        end else if (host_req) begin
            pick_host = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = ACC;
                end
            end
            ACC: begin
                state_nx = we_q ? IDLE : RD;
            end
            RD: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            last_win   <= 1'b1;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                win_q     <= pick_host;
                last_win  <= pick_host;
                we_q      <= pick_host ? host_we : cpu_we;
                mem_addr  <= pick_host ? host_addr : cpu_addr;
                mem_wdata <= pick_host ? host_wdata : cpu_wdata;
                // HOST can only lose on a tie, so that is the starvation case.
                if (pick_host) begin
                    starve_cnt <= '0;
                end else if (host_req && starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end

    assign cpu_gnt     = (state == ACC) && !win_q;
    assign host_gnt    = (state == ACC) && win_q;
    assign cpu_rvalid  = (state == RD) && !win_q;
    assign host_rvalid = (state == RD) && win_q;
    assign mem_we      = (state == ACC) && we_q;
    assign rdata       = (state == RD) ? mem_rdata : '0;
    assign arb_state   = state;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/read data,
// negedge monitors pop and compare whenever the arbiter responds.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } gexp_t;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } rexp_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [15:0] rdata, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [7:0]  mem_addr;
    logic        mem_we, busy;
    logic [1:0]  arb_state;

    logic        f_cpu_req = 1'b0, f_host_req = 1'b0;
    logic        f_cpu_gnt, f_cpu_rvalid, f_host_gnt, f_host_rvalid;
    logic [15:0] f_rdata, f_mem_wdata;
    logic [15:0] f_mem_rdata = '0;
    logic [7:0]  f_mem_addr;
    logic        f_mem_we, f_busy;
    logic [1:0]  f_arb_state;

    logic [15:0] ram [256];

    gexp_t gq[$];
    rexp_t rq[$];
    logic  fq[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.FIXED_PRI(0), .STARVE_MAX(3)) dut (
        .clk(clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .arb_state(arb_state), .busy(busy)
    );

    dmem_arbiter #(.FIXED_PRI(1), .STARVE_MAX(3)) dut_fix (
        .clk(clk), .Reset(Reset),
        .cpu_req(f_cpu_req), .cpu_we(1'b1),
        .cpu_addr(8'h01), .cpu_wdata(16'h1111),
        .cpu_gnt(f_cpu_gnt), .cpu_rvalid(f_cpu_rvalid),
        .host_req(f_host_req), .host_we(1'b1),
        .host_addr(8'h02), .host_wdata(16'h2222),
        .host_gnt(f_host_gnt), .host_rvalid(f_host_rvalid),
        .rdata(f_rdata), .mem_addr(f_mem_addr), .mem_we(f_mem_we),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata),
        .arb_state(f_arb_state), .busy(f_busy)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic gnt_of(input int w);
        case (w)
            0: return cpu_gnt;
            1: return host_gnt;
            2: return f_cpu_gnt;
            default: return f_host_gnt;
        endcase
    endfunction

    function automatic logic rv_of(input int w);
        return (w == 0) ? cpu_rvalid : host_rvalid;
    endfunction

    task automatic set_req(input int w, input logic v);
        case (w)
            0: cpu_req = v;
            1: host_req = v;
            2: f_cpu_req = v;
            default: f_host_req = v;
        endcase
    endtask

    // Main-DUT monitor.
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        if (cpu_gnt || host_gnt) begin
            if (gq.size() == 0) begin
                chk("gnt_unexpected", {cpu_gnt, host_gnt}, 2'b00);
            end else begin
                g = gq.pop_front();
                chk("gnt", {cpu_gnt, host_gnt, mem_we, mem_addr, mem_wdata},
                    {~g.port, g.port, g.we, g.addr, g.wdata});
            end
        end else if (mem_we) begin
            chk("we_stray", mem_we, 1'b0);
        end
        if (cpu_rvalid || host_rvalid) begin
            if (rq.size() == 0) begin
                chk("rv_unexpected", {cpu_rvalid, host_rvalid}, 2'b00);
            end else begin
                r = rq.pop_front();
                chk("rvalid", {cpu_rvalid, host_rvalid, rdata},
                    {~r.port, r.port, r.data});
            end
        end
    end

    // Fixed-priority DUT monitor.
    always @(negedge clk) begin
        logic p;
        if (f_cpu_gnt || f_host_gnt) begin
            if (fq.size() == 0) begin
                chk("fgnt_unexpected", {f_cpu_gnt, f_host_gnt}, 2'b00);
            end else begin
                p = fq.pop_front();
                chk("fgnt", {f_cpu_gnt, f_host_gnt}, {~p, p});
            end
        end
    end

    task automatic access(input int port, input logic we,
                          input logic [7:0] addr, input logic [15:0] wd,
                          input logic [15:0] exp_rd);
        gq.push_back('{port[0], we, addr, wd});
        if (!we) rq.push_back('{port[0], exp_rd});
        @(posedge clk);
        #1;
        if (port == 1) begin
            host_we = we; host_addr = addr; host_wdata = wd;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        set_req(port, 1'b1);
        @(negedge clk);
        chk("st_idle", arb_state, 2'd0);
        @(negedge clk);
        chk("gnt_lat", gnt_of(port), 1'b1);
        chk("st_acc", {busy, arb_state}, 3'b101);
        @(posedge clk);
        #1;
        set_req(port, 1'b0);
        @(negedge clk);
        if (!we) begin
            chk("st_rd", arb_state, 2'd2);
            chk("rv_lat", rv_of(port), 1'b1);
            @(negedge clk);
        end
        chk("st_back", {busy, arb_state}, 3'b000);
    endtask

    task automatic hold_until(input int w, input int n);
        int c = 0;
        int t = 0;
        while (c < n && t < 200) begin
            @(negedge clk);
            t++;
            if (gnt_of(w)) c++;
        end
        chk("grants", c, n);
        @(posedge clk);
        #1;
        set_req(w, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        ram[8'h30] = 16'hA5A5;
        ram[8'h31] = 16'h5A5A;
        ram[8'h40] = 16'h1357;
        repeat (2) @(negedge clk);
        chk("reset_outs",
            {cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, rdata, mem_addr,
             mem_we, mem_wdata, arb_state, busy}, 48'h0);
        @(posedge clk);
        #1;
        Reset = 1'b1;

        access(0, 1'b1, 8'h10, 16'h1234, 16'h0);
        access(0, 1'b0, 8'h10, 16'h0, 16'h1234);

        // HOST read cut by reset during RD: only its grant may be seen.
        gq.push_back('{1'b1, 1'b0, 8'h40, 16'h0});
        @(posedge clk);
        #1;
        host_we = 1'b0; host_addr = 8'h40; host_wdata = 16'h0;
        host_req = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        host_req = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        chk("rst_rd_outs",
            {cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, rdata, mem_addr,
             mem_we, mem_wdata, arb_state, busy}, 48'h0);
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b1;
        access(1, 1'b0, 8'h40, 16'h0, 16'h1357);

        // Round-robin: both held, CPU wins first since HOST won last.
        cpu_we = 1'b0; cpu_addr = 8'h30; cpu_wdata = 16'h0;
        host_we = 1'b0; host_addr = 8'h31; host_wdata = 16'h0;
        for (int i = 0; i < 2; i++) begin
            gq.push_back('{1'b0, 1'b0, 8'h30, 16'h0});
            gq.push_back('{1'b1, 1'b0, 8'h31, 16'h0});
            rq.push_back('{1'b0, 16'hA5A5});
            rq.push_back('{1'b1, 16'h5A5A});
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        host_req = 1'b1;
        fork
            hold_until(0, 2);
            hold_until(1, 2);
        join
        repeat (4) @(negedge clk);

        access(1, 1'b1, 8'h22, 16'hBEEF, 16'h0);
        access(0, 1'b0, 8'h22, 16'h0, 16'hBEEF);

        // Fixed priority: CPU x3, starved HOST, then CPU.
        fq.push_back(1'b0);
        fq.push_back(1'b0);
        fq.push_back(1'b0);
        fq.push_back(1'b1);
        fq.push_back(1'b0);
        @(posedge clk);
        #1;
        f_cpu_req = 1'b1;
        f_host_req = 1'b1;
        fork
            hold_until(2, 4);
            hold_until(3, 1);
        join

        repeat (4) @(negedge clk);
        chk("gq_left", gq.size(), 0);
        chk("rq_left", rq.size(), 0);
        chk("fq_left", fq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 256x16 data memory between two requesters: the processor datapath (port 0, CPU) and a host/debug loader (port 1, HOST). It arbitrates per access, sequences the synchronous RAM through a 3-state FSM, and returns read data with a valid strobe. It sits between DataPath/ControlUnit and the data RAM, and exports its state for debug like the processor does.

Parameters:
ADDR_W, 8, data memory address width
DATA_W, 16, data word width
FIXED_PRI, 0, 0 = round-robin; 1 = CPU has fixed priority with starvation guard
STARVE_MAX, 3, in fixed-priority mode, consecutive HOST losses before HOST is forced to win

Ports:
clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU access request, held until cpu_gnt
cpu_we  input  1  1 = write, 0 = read; valid with cpu_req
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_gnt  output  1  one-cycle grant pulse
cpu_rvalid  output  1  one-cycle read-data-valid pulse
host_req/host_we/host_addr/host_wdata  input  1/1/ADDR_W/DATA_W  HOST equivalents
host_gnt  output  1  one-cycle grant pulse
host_rvalid  output  1  one-cycle read-data-valid pulse
rdata  output  DATA_W  read data, shared; qualify with *_rvalid
mem_addr  output  ADDR_W  RAM address
mem_we  output  1  RAM write enable
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM output, valid 1 cycle after address is presented
arb_state  output  2  FSM state: 0 IDLE, 1 ACC, 2 RD
busy  output  1  1 when arb_state != IDLE

Behaviour:
- Reset low (async): state IDLE; all outputs 0; last_winner = HOST (CPU wins the first tie); starve_cnt = 0. An in-flight access is dropped, with no gnt or rvalid, and the requester must re-request.
- IDLE: if no req, stay. Otherwise pick the winner. At the next edge, register the winner's we/addr/wdata onto mem_*, set its gnt, and go to ACC.
- ACC (1 cycle): mem_addr/mem_wdata hold the latched values; mem_we = latched we; winner gnt = 1. Write goes to IDLE; read goes to RD.
- RD (1 cycle): rdata = mem_rdata; winner rvalid = 1; mem_we = 0. Then go to IDLE.
- Latency from req seen in IDLE: gnt and RAM access in the next cycle, read data 2 cycles later. Throughput: one write per 2 cycles, one read per 3 cycles.
- Requester drops req or changes fields at the edge ending its gnt cycle. A req still high when IDLE samples it is a new request.
- Inputs are ignored outside IDLE. Request fields are sampled only in IDLE.
- Round-robin (FIXED_PRI=0): single requester wins. On a tie, the requester not equal to last_winner wins. last_winner updates on every grant.
- Fixed priority (FIXED_PRI=1): on a tie, CPU wins unless starve_cnt == STARVE_MAX, in which case HOST wins.
  - starve_cnt increments, saturating, on each arbitration where HOST requested and lost.
  - starve_cnt clears when HOST wins.
- mem_addr/mem_wdata hold their last value in IDLE. mem_we is 1 only in ACC for writes.
- gnt and rvalid are never asserted for both ports in the same cycle.

Test Plan:
- Reset low 2 cycles, release; CPU write addr 0x10 data 0x1234 -> cpu_gnt=1 and mem_we=1 with mem_addr=0x10 in the cycle after req; state 0->1->0.
- CPU read 0x10 (RAM holds 0x1234) -> cpu_gnt at T+1, cpu_rvalid=1 and rdata=0x1234 at T+2; host signals stay 0.
- Round-robin: both req held continuously for 4 reads -> grant order CPU, HOST, CPU, HOST; each rvalid goes to the matching port.
- FIXED_PRI=1, STARVE_MAX=3, both req held continuously (writes) -> CPU wins 3 times, HOST wins the 4th, CPU wins the 5th.
- Reset asserted during RD of a HOST read -> all outputs 0 immediately, no host_rvalid, state 0; after release, the re-issued HOST read completes normally.
- HOST write 0x22 := 0xBEEF followed by a CPU read of 0x22 -> cpu_rvalid with rdata=0xBEEF.
